rx_depuncturer: RTL and testbench
=================================

Name: rx_depuncturer

Overview:
- Receive-side counterpart of the transmit puncturer.
- Accepts the punctured coded bit stream as soft decisions, one per beat, from the deinterleaver/demapper.
- Re-inserts erased positions according to the 802.11a puncturing pattern for rate 1/2, 2/3 or 3/4.
- Emits (A,B) soft pairs with per-bit erasure flags to the Viterbi decoder over a valid/ready handshake.

Parameters:
- SW, 3: soft-decision width in bits (two's complement).
- ERASE_VAL, 0: soft value driven on an erased output bit.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cr  in  2  code rate: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts input beat
- in_data  in  SW  received soft coded bit
- in_sop  in  1  first coded bit of packet; resyncs the pattern phase
- in_last  in  1  last coded bit of packet
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts pair
- out_a  out  SW  soft value, first encoder output (A)
- out_b  out  SW  soft value, second encoder output (B)
- out_ea  out  1  out_a is an erasure
- out_eb  out  1  out_b is an erasure
- out_last  out  1  pair is the last of the packet
- err  out  1  sticky: reserved cr or dangling bit at in_last; cleared by sop

Behaviour:
- Reset (rst low, async): phase=P0, rate register=00, held A register=0, out_valid=0, out_a=out_b=0, out_ea=out_eb=0, out_last=0, err=0.
- Handshake:
  - Input beat accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, so full throughput with a single output register.
  - Output fields stable while out_valid && !out_ready.
- Rate latch:
  - cr sampled into the rate register on an accepted beat with in_sop=1; that beat is treated as phase P0.
  - cr=11 latches as rate 1/2 and sets err.
  - cr changes between sops are ignored.
- Phase machine, advanced only on accepted beats:
  - Rate 1/2:
    - P0: hold A → P1.
    - P1: emit (A, in) → P0.
  - Rate 2/3:
    - P0: hold A1 → P1.
    - P1: emit (A1, B1) → P2.
    - P2: emit (in, E) with eb=1 → P0.
  - Rate 3/4:
    - P0: hold A1 → P1.
    - P1: emit (A1, B1) → P2.
    - P2: emit (in, E) with eb=1 → P3.
    - P3: emit (E, in) with ea=1 → P0.
- Erasure: an erased field carries ERASE_VAL, and its flag is 1. Non-erased fields are copied unchanged, with no arithmetic.
- Latency: a pair is registered on the clock edge that accepts its completing beat; out_valid rises the next cycle.
- Ratio per period: rate 1/2 is 2 in / 1 out; 2/3 is 3 in / 2 out; 3/4 is 4 in / 3 out.
- Each accepted beat produces at most one pair, so no second buffer is needed.
- in_last:
  - The pair produced by that beat carries out_last=1, and phase returns to P0.
  - If in_last arrives at P0 (dangling A), emit (in, E) with eb=1 and out_last=1, and set err.
- in_sop at a nonzero phase: the held A is discarded, phase is forced to P0, and the new beat is held as A. No output is produced for the discarded bit.
- Simultaneous in_sop and in_last on one beat: treat as P0 with dangling, i.e. emit (in, E), out_last=1, err=1.
- err clears on an accepted sop beat, then re-evaluates on that same beat.
- Reset mid-packet discards held A and any pending output pair immediately.

Test Plan:
- Rate 1/2, sop on first beat, inputs 1,-1,2,-2, out_ready=1:
  - 2 pairs, (1,-1) then (2,-2), all flags 0.
  - Each pair one cycle after its completing beat; last pair out_last=1 when in_last is on beat 4.
- Rate 2/3, inputs 1,2,3,-1,-2,-3 with in_last on beat 6:
  - Pairs (1,2), (3,E eb=1), (-1,-2), (-3,E eb=1), with out_last=1 on the 4th pair.
- Rate 3/4, inputs 1,2,3,-3 repeated twice:
  - Pairs (1,2), (3,E eb=1), (E ea=1,-3), repeated, giving 6 pairs.
  - ERASE_VAL=0 on erased fields.
- Backpressure, rate 3/4, out_ready low for 3 cycles mid-stream:
  - in_ready low while a pair is held; output fields stable.
  - No beat lost or duplicated; sequence identical to the no-stall run.
- Edge cases:
  - cr=11 at sop → err=1, rate 1/2 behaviour.
  - in_last at P0 with value 2 → pair (2,E eb=1), out_last=1, err=1.
  - Next sop with cr=01 → err=0.
- Async reset asserted mid-period (phase P2, out_valid=1):
  - All outputs zero immediately.
  - After release, a new sop restarts cleanly at P0.

Source files
------------

// File: rtl/rx_depuncturer.sv
// rx_depuncturer: re-inserts 802.11a punctured positions (rate 1/2, 2/3, 3/4) as flagged
// erasures and emits (A,B) soft pairs to the Viterbi decoder over valid/ready.
module rx_depuncturer #(
  parameter int SW = 3,
  parameter logic [SW-1:0] ERASE_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_data,
  input  logic          in_sop,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_a,
  output logic [SW-1:0] out_b,
  output logic          out_ea,
  output logic          out_eb,
  output logic          out_last,
  output logic          err
);
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;
  phase_t phase, cur, phase_n;
  logic [1:0] rate, rate_n;
  logic [SW-1:0] hold, hold_n, a_n, b_n;
  logic acc, emit, ea_n, eb_n, err_n;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  // A sop beat always restarts at P0 with a freshly latched rate; reserved cr runs as 1/2.
  always_comb begin
    rate_n = in_sop ? (cr == 2'b11 ? 2'b00 : cr) : rate;
    cur = in_sop ? P0 : phase;
    err_n = (in_sop ? 1'b0 : err) | (in_sop && cr == 2'b11);
    phase_n = cur;
    hold_n = hold;
    emit = 1'b1;
    a_n = in_data;
    b_n = ERASE_VAL;
    ea_n = 1'b0;
    eb_n = 1'b1;
    case (cur)
      P0: if (in_last) err_n = 1'b1;
          else begin
            emit = 1'b0;
            hold_n = in_data;
            phase_n = P1;
          end
      P1: begin
        a_n = hold;
        b_n = in_data;
        eb_n = 1'b0;
        phase_n = rate_n == 2'b00 ? P0 : P2;
      end
      P2: phase_n = rate_n == 2'b10 ? P3 : P0;
      default: begin
        a_n = ERASE_VAL;
        b_n = in_data;
        ea_n = 1'b1;
        eb_n = 1'b0;
        phase_n = P0;
      end
    endcase
    if (in_last) phase_n = P0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= P0;
      rate <= 2'b00;
      hold <= '0;
      err <= 1'b0;
      out_valid <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_ea <= 1'b0;
      out_eb <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (acc) begin
        phase <= phase_n;
        rate <= rate_n;
        hold <= hold_n;
        err <= err_n;
      end
      if (acc && emit) begin
        out_valid <= 1'b1;
        out_a <= a_n;
        out_b <= b_n;
        out_ea <= ea_n;
        out_eb <= eb_n;
        out_last <= in_last;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rx_depuncturer.sv
// tb_rx_depuncturer: randomized and directed checks of rx_depuncturer against a
// pair-oriented puncturing model (kept/erased field pattern per mother-code pair).
module tb_rx_depuncturer;
  localparam int SW = 3;
  typedef struct packed {logic [SW-1:0] a, b; logic ea, eb, last;} pair_t;
  logic clk = 0, rst = 0, in_valid = 0, in_sop = 0, in_last = 0, out_ready = 1;
  logic [1:0] cr = 0;
  logic [SW-1:0] in_data = 0;
  logic in_ready, out_valid, out_ea, out_eb, out_last, err;
  logic [SW-1:0] out_a, out_b;
  int checks = 0, errors = 0, stall_mode = 0, stall_cnt = 0;
  pair_t obs[$], exp_q[$];
  bit exp_err;
  always #5 clk = ~clk;
  rx_depuncturer #(.SW(SW), .ERASE_VAL('0)) dut (
    .clk(clk), .rst(rst), .cr(cr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_ea(out_ea),
    .out_eb(out_eb), .out_last(out_last), .err(err)
  );
  initial forever begin
    @(negedge clk);
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else out_ready = stall_mode == 0 ? 1'b1 : stall_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  // Records transferred pairs and checks that a stalled pair does not change.
  initial begin
    pair_t held;
    bit stalled;
    stalled = 0;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && stalled) begin
        checks++;
        if ({out_a, out_b, out_ea, out_eb, out_last} !== held) begin
          errors++;
          $display("FAIL stable: got %h want %h", {out_a, out_b, out_ea, out_eb, out_last}, held);
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_a, out_b, out_ea, out_eb, out_last};
      if (out_valid && out_ready) obs.push_back({out_a, out_b, out_ea, out_eb, out_last});
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // Mother-code pair j of a period: field A punctured on pair 2 (rate 3/4), field B on pair 1.
  function automatic bit model(input logic [1:0] c, input logic [SW-1:0] d[$], input bit last,
                               output pair_t q[$]);
    int np, i, j;
    bit ka, kb, dang;
    pair_t p;
    np = (c == 2'b11) ? 1 : int'(c) + 1;
    i = 0;
    j = 0;
    dang = 0;
    q = {};
    while (i < d.size()) begin
      ka = (j % np) != 2;
      kb = (j % np) != 1;
      p = '0;
      p.ea = !ka;
      p.eb = !kb;
      if (ka) begin
        p.a = d[i];
        i++;
      end
      if (kb) begin
        if (i < d.size()) begin
          p.b = d[i];
          i++;
        end else if (last) begin
          p.eb = 1;
          dang = 1;
        end else break;
      end
      q.push_back(p);
      j++;
    end
    if (last && q.size() > 0) q[q.size()-1].last = 1;
    return dang;
  endfunction
  task automatic run(input logic [1:0] c, input logic [SW-1:0] d[$], input bit last, input bit gaps);
    pair_t q[$];
    exp_err = model(c, d, last, q) || c == 2'b11;
    foreach (q[k]) exp_q.push_back(q[k]);
    for (int i = 0; i < d.size(); i++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 0;
        @(negedge clk);
      end
      in_valid = 1;
      in_data = d[i];
      in_sop = i == 0;
      in_last = last && i == d.size() - 1;
      cr = i == 0 ? c : 2'($urandom);
      #1;
      for (int g = 0; !in_ready; g++) begin
        if (g == 200) begin
          checks++;
          errors++;
          $display("FAIL in_ready timeout: got 0 want 1");
          break;
        end
        @(negedge clk);
        #1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0;
    in_sop = 0;
    in_last = 0;
  endtask
  task automatic drain();
    for (int c = 0; c < 300 && obs.size() < exp_q.size(); c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    #12;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if ({out_a, out_b, out_ea, out_eb, out_last} !== '0) begin
      errors++;
      $display("FAIL reset fields: got %h want 0", {out_a, out_b, out_ea, out_eb, out_last});
    end
    if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1;
  endtask
  task automatic test_latency();
    obs.delete();
    exp_q.delete();
    @(negedge clk);
    in_valid = 1; in_sop = 1; cr = 0; in_data = 3'd1; in_last = 0;
    @(negedge clk);
    in_sop = 0; in_data = 3'b111; in_last = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency early: got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 0; in_last = 0;
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_ea, out_eb, out_last} !== {1'b1, 3'd1, 3'b111, 3'b001}) begin
      errors++;
      $display("FAIL latency pair: got %h want %h", {out_valid, out_a, out_b, out_ea, out_eb, out_last},
               {1'b1, 3'd1, 3'b111, 3'b001});
    end
    drain();
  endtask
  task automatic test_rate12();
    logic [SW-1:0] d[$];
    obs.delete();
    exp_q.delete();
    d = '{3'd1, 3'b111, 3'd2, 3'b110};
    run(2'b00, d, 1, 0);
    drain();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL r12 count: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL r12 pair %0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask
  task automatic test_rate23();
    logic [SW-1:0] d[$];
    obs.delete();
    exp_q.delete();
    d = '{3'd1, 3'd2, 3'd3, 3'b111, 3'b110, 3'b101};
    run(2'b01, d, 1, 0);
    drain();
    checks += 2;
    if (obs.size() !== 4) begin errors++; $display("FAIL r23 count: got %0d want 4", obs.size()); end
    if (err !== 1'b0) begin errors++; $display("FAIL r23 err: got %b want 0", err); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL r23 pair %0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask
  task automatic test_rate34(input bit stall);
    logic [SW-1:0] d[$];
    obs.delete();
    exp_q.delete();
    d = '{3'd1, 3'd2, 3'd3, 3'b101, 3'd1, 3'd2, 3'd3, 3'b101};
    fork
      run(2'b10, d, 1, 0);
      if (stall) begin
        repeat (4) @(negedge clk);
        stall_cnt = 3;
      end
    join
    drain();
    checks++;
    if (obs.size() !== 6) begin errors++; $display("FAIL r34 count stall=%0d: got %0d want 6", stall, obs.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL r34 pair %0d stall=%0d: got %h want %h", i, stall, obs[i], exp_q[i]); end
    end
  endtask
  task automatic test_edge_cases();
    logic [SW-1:0] d[$];
    obs.delete();
    exp_q.delete();
    d = '{3'd1, 3'b111, 3'd2, 3'b110};
    run(2'b11, d, 1, 0);
    drain();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL reserved cr err: got %b want 1", err); end
    d = '{3'd1, 3'b111, 3'd2};
    run(2'b00, d, 1, 0);
    drain();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL dangling err: got %b want 1", err); end
    d = '{3'd1, 3'b111, 3'd2};
    run(2'b00, d, 0, 0);
    d = '{3'd3, 3'b101, 3'd1};
    run(2'b01, d, 1, 0);
    drain();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL sop clears err: got %b want 0", err); end
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL edge count: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL edge pair %0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask
  task automatic test_random();
    logic [SW-1:0] d[$];
    obs.delete();
    exp_q.delete();
    stall_mode = 1;
    for (int p = 0; p < 25; p++) begin
      d = {};
      repeat ($urandom_range(1, 12)) d.push_back(SW'($urandom));
      run(2'($urandom), d, $urandom_range(0, 3) != 0, 1);
      drain();
      checks++;
      if (err !== exp_err) begin errors++; $display("FAIL random err pkt %0d: got %b want %b", p, err, exp_err); end
    end
    stall_mode = 0;
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL random count: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL random pair %0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask
  task automatic test_async_reset();
    logic [SW-1:0] d[$];
    stall_mode = 2;
    @(negedge clk);
    in_valid = 1; in_sop = 1; cr = 2'b10; in_data = 3'd1; in_last = 0;
    @(negedge clk);
    in_sop = 0; in_data = 3'd2;
    @(negedge clk);
    in_data = 3'd3;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL arst pre out_valid: got %b want 1", out_valid); end
    #1;
    rst = 0;
    #1;
    checks += 2;
    if ({out_valid, out_a, out_b, out_ea, out_eb, out_last, err} !== '0) begin
      errors++;
      $display("FAIL arst outputs: got %h want 0", {out_valid, out_a, out_b, out_ea, out_eb, out_last, err});
    end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL arst in_ready: got %b want 1", in_ready); end
    in_valid = 0;
    stall_mode = 0;
    @(negedge clk);
    rst = 1;
    obs.delete();
    exp_q.delete();
    d = '{3'd3, 3'b101};
    run(2'b00, d, 1, 0);
    drain();
    checks++;
    if (obs.size() !== 1) begin errors++; $display("FAIL arst restart count: got %0d want 1", obs.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL arst restart pair: got %h want %h", obs[i], exp_q[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_rate12();
    test_rate23();
    test_rate34(0);
    test_rate34(1);
    test_edge_cases();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
